sampler_voice_addr_ctrl: RTL
============================

Name: sampler_voice_addr_ctrl

Overview:
Polyphonic successor to the single-voice sampler address path. It holds NUM_VOICES independent playback voices, each driven by its own keycode. On every sample tick it time-multiplexes one shared sample-memory read port across the voices. Key-to-base-address translation is done by an external keymapper, which this block drives through a combinational lookup port. The block sits between the keyboard/keycode logic and the sample SRAM/flash reader feeding the mixer.

Parameters:
NUM_VOICES, 4, number of simultaneous voices (1..16)
KEY_W, 8, keycode width
ADDR_W, 20, sample memory address width
CNT_W, 16, per-voice sample counter width
NOTE_LEN, 16000, samples per note; must be >=1 and <2^CNT_W

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
sample_clk  in  1  sample-rate strobe, synchronous to Clk; rising edge starts a frame
loop_en  in  1  1 = voice restarts at base after NOTE_LEN samples; 0 = one-shot
keycodes  in  NUM_VOICES*KEY_W  packed per-voice keycodes; voice v at [v*KEY_W +: KEY_W]; 0 = no key
map_key  out  KEY_W  keycode presented to the keymapper (keycode of the voice being serviced)
map_addr  in  ADDR_W  keymapper base address for map_key, combinational, same cycle
map_invalid  in  1  keymapper flags map_key as unmapped
mem_req  out  1  read request to sample memory
mem_addr  out  ADDR_W  read address; stable while mem_req=1
mem_voice  out  clog2(NUM_VOICES) (min 1)  voice index of the current request
mem_ack  in  1  memory accepted the request
voice_active  out  NUM_VOICES  voice is playing
frame_done  out  1  one-cycle pulse after the last voice of a frame is serviced
overrun  out  1  sticky: a sample_clk edge arrived while a frame was still in progress

Behaviour:
- Reset (async, Reset=0): all outputs 0. FSM goes to IDLE. All per-voice addr, cnt, last_key, finished and active are cleared. sample_clk edge register is cleared. Asserting reset mid-request drops mem_req immediately.
- Edge detect: a registered copy of sample_clk is kept. An edge is sample_clk=1 while the registered copy is 0. In IDLE, an edge at cycle t puts the FSM in SERVE with v=0 at t+1.
- FSM states: IDLE, SERVE, WAIT_ACK, DONE.
- SERVE(v): map_key = key[v]. Evaluate in order; the first matching case applies:
  a) key[v]==0 or map_invalid: active[v]<=0, finished[v]<=0, last_key[v]<=key[v], cnt<=0. No request. Advance.
  b) key[v]!=last_key[v] (new note): addr[v]<=map_addr, cnt[v]<=0, last_key<=key, finished<=0, active<=1. Enter WAIT_ACK with mem_addr=map_addr.
  c) finished[v]: no request; voice stays silent until the key changes or is released. Advance.
  d) otherwise: enter WAIT_ACK with mem_addr=addr[v].
  - Advance means v+1 -> SERVE, or after v==NUM_VOICES-1 -> DONE. Each skipped voice costs exactly one cycle.
- WAIT_ACK: mem_req=1; mem_addr and mem_voice are held. On mem_ack, apply the voice update and advance:
  - If cnt+1==NOTE_LEN and loop_en=1: addr<=last base address (stored per voice), cnt<=0.
  - If cnt+1==NOTE_LEN and loop_en=0: finished<=1, active<=0.
  - Otherwise: addr<=addr+1 (wraps modulo 2^ADDR_W), cnt<=cnt+1.
  - mem_req deasserts in the cycle after the ack.
- DONE: frame_done=1 for one cycle, then IDLE.
- mem_ack while mem_req=0 is ignored.
- A sample_clk edge in any non-IDLE state sets overrun (cleared only by reset). The edge is dropped.
- A keycode change mid-frame takes effect for voice v only when v is serviced.
- With NOTE_LEN=1: every sample is both the first and last sample of the note.
- The per-voice base address is latched on a new note. A map_addr change during playback has no effect.

Test Plan:
- Reset, then NUM_VOICES=4, voice0 key=0x1C with map_addr=0x01000, others 0, mem_ack tied 1. Tick sample_clk 3x -> mem_addr 0x01000, 0x01001, 0x01002 with mem_voice=0, one frame_done per tick, voice_active=4'b0001.
- NOTE_LEN=4, loop_en=0, one key held for 6 ticks -> 4 requests (base..base+3), then no mem_req, voice_active[0]=0. Release key, re-press -> playback restarts at base.
- Same as previous with loop_en=1 -> address sequence base, +1, +2, +3, base, +1.
- Voices 0 and 2 active, mem_ack delayed 3 cycles per request -> requests in order voice0 then voice2. mem_addr stable throughout the wait. Voices 1 and 3 skipped in one cycle each. frame_done follows voice2's ack.
- Second sample_clk edge during WAIT_ACK -> overrun=1 and stays 1. The frame completes normally. No extra frame is started.
- Key change 0x1C->0x1D mid-playback (map_addr 0x02000) -> next service requests 0x02000 with cnt reset. An unmapped key (map_invalid=1) -> voice inactive, no request. Reset asserted during WAIT_ACK -> mem_req=0 immediately and all outputs are 0.

Source files
------------

// File: rtl/sampler_voice_addr_ctrl.sv
// sampler_voice_addr_ctrl
//   Polyphonic sample-address generator. Each sample tick (rising edge of
//   i_sample_clk) starts a frame that walks voices 0..NUM_VOICES-1. Each voice
//   gets at most one read on a shared sample-memory port. Base addresses come
//   from an external combinational keymapper driven through o_map_key.
//
// Ports
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_sample_clk      sample-rate strobe; a rising edge starts a frame
//   i_loop_en         1: voice restarts at its base after NOTE_LEN samples
//   i_keycodes        packed per-voice keycodes, voice v at [v*KEY_W +: KEY_W]
//   o_map_key         keycode of the voice being serviced (to keymapper)
//   i_map_addr        keymapper base address for o_map_key (same cycle)
//   i_map_invalid     keymapper reports o_map_key as unmapped
//   o_mem_req         sample-memory read request
//   o_mem_addr        read address, held while o_mem_req=1
//   o_mem_voice       voice index of the current request
//   i_mem_ack         memory accepted the request
//   o_voice_active    per-voice playing flag
//   o_frame_done      one-cycle pulse after the last voice of a frame
//   o_overrun         sticky: a tick arrived while a frame was in progress
module sampler_voice_addr_ctrl #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned KEY_W      = 8,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NOTE_LEN   = 16000,
  localparam int unsigned VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_sample_clk,
  input  logic                        i_loop_en,
  input  logic [NUM_VOICES*KEY_W-1:0] i_keycodes,
  output logic [KEY_W-1:0]            o_map_key,
  input  logic [ADDR_W-1:0]           i_map_addr,
  input  logic                        i_map_invalid,
  output logic                        o_mem_req,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [VW-1:0]               o_mem_voice,
  input  logic                        i_mem_ack,
  output logic [NUM_VOICES-1:0]       o_voice_active,
  output logic                        o_frame_done,
  output logic                        o_overrun
);

  typedef enum logic [1:0] {StIdle, StServe, StWaitAck, StDone} state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic                  r_sclk_q;
  logic                  r_overrun;
  logic [VW-1:0]         r_v;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [ADDR_W-1:0]     r_addr     [NUM_VOICES];
  logic [ADDR_W-1:0]     r_base     [NUM_VOICES];
  logic [CNT_W-1:0]      r_cnt      [NUM_VOICES];
  logic [KEY_W-1:0]      r_last_key [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_finished;
  logic [NUM_VOICES-1:0] r_active;

  logic              w_edge;
  logic [KEY_W-1:0]  w_key;
  logic              w_silent;
  logic              w_new;
  logic              w_skip_fin;
  logic              w_last;
  logic              w_advance;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_note_end;

  assign w_edge = i_sample_clk & ~r_sclk_q;

  always_comb begin
    w_key = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_v == VW'(i)) w_key = i_keycodes[i*KEY_W +: KEY_W];
    end
  end

  // Service classification for voice r_v; first match wins.
  assign w_silent   = (w_key == '0) || i_map_invalid;
  assign w_new      = !w_silent && (w_key != r_last_key[r_v]);
  assign w_skip_fin = !w_silent && !w_new && r_finished[r_v];
  assign w_last     = (r_v == VW'(NUM_VOICES - 1));
  // cnt < NOTE_LEN < 2^CNT_W, so the increment cannot overflow.
  assign w_cnt_next = r_cnt[r_v] + CNT_W'(1);
  assign w_note_end = (w_cnt_next == CNT_W'(NOTE_LEN));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      StIdle:    if (w_edge) w_state_nxt = StServe;
      StServe: begin
        if (w_silent || w_skip_fin) w_advance = 1'b1;
        else                        w_state_nxt = StWaitAck;
      end
      StWaitAck: if (i_mem_ack) w_advance = 1'b1;
      StDone:    w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
    if (w_advance) w_state_nxt = w_last ? StDone : StServe;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_q   <= 1'b0;
      r_overrun  <= 1'b0;
      r_v        <= '0;
      r_mem_addr <= '0;
      r_finished <= '0;
      r_active   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_addr[i]     <= '0;
        r_base[i]     <= '0;
        r_cnt[i]      <= '0;
        r_last_key[i] <= '0;
      end
    end else begin
      r_sclk_q <= i_sample_clk;
      // Ticks during a frame are dropped but remembered.
      if (w_edge && (r_state != StIdle)) r_overrun <= 1'b1;
      if (w_advance && !w_last) r_v <= r_v + VW'(1);
      case (r_state)
        StIdle: if (w_edge) r_v <= '0;
        StServe: begin
          if (w_silent) begin
            r_active[r_v]   <= 1'b0;
            r_finished[r_v] <= 1'b0;
            r_last_key[r_v] <= w_key;
            r_cnt[r_v]      <= '0;
          end else if (w_new) begin
            r_addr[r_v]     <= i_map_addr;
            r_base[r_v]     <= i_map_addr;
            r_cnt[r_v]      <= '0;
            r_last_key[r_v] <= w_key;
            r_finished[r_v] <= 1'b0;
            r_active[r_v]   <= 1'b1;
            r_mem_addr      <= i_map_addr;
          end else if (!r_finished[r_v]) begin
            r_mem_addr <= r_addr[r_v];
          end
        end
        StWaitAck: begin
          if (i_mem_ack) begin
            if (w_note_end && i_loop_en) begin
              r_addr[r_v] <= r_base[r_v];
              r_cnt[r_v]  <= '0;
            end else if (w_note_end) begin
              r_finished[r_v] <= 1'b1;
              r_active[r_v]   <= 1'b0;
            end else begin
              r_addr[r_v] <= r_addr[r_v] + ADDR_W'(1);
              r_cnt[r_v]  <= w_cnt_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_map_key      = (r_state == StServe) ? w_key : '0;
  assign o_mem_req      = (r_state == StWaitAck);
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_voice    = r_v;
  assign o_frame_done   = (r_state == StDone);
  assign o_voice_active = r_active;
  assign o_overrun      = r_overrun;

endmodule
